// File: rtl/ula_operand_stage_if.sv
// Bus bundle around ula_operand_stage: instruction handshake, ALU operand/result port,
// writeback report and debug register-file read. The stage uses the slave modport.
interface ula_operand_stage_if;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instrWord;

  logic [31:0] input1;
  logic [31:0] input2;
  logic [1:0]  aluOp;
  logic [5:0]  funct;
  logic [5:0]  opCode;
  logic [31:0] aluResult;

  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic [31:0] wbTag;
  logic        illegalInstr;

  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;

  modport master (
    output instrValid, instrWord, aluResult, dbgAddr,
    input  instrReady, input1, input2, aluOp, funct, opCode,
    input  wbValid, wbAddr, wbData, wbTag, illegalInstr, dbgData
  );

  modport slave (
    input  instrValid, instrWord, aluResult, dbgAddr,
    output instrReady, input1, input2, aluOp, funct, opCode,
    output wbValid, wbAddr, wbData, wbTag, illegalInstr, dbgData
  );
endinterface

// File: rtl/ula_operand_stage.sv
// Issue/writeback stage around the Ula ALU: decode, operand read, execute, writeback.
// Optional feature: define ULA_STAGE_ORI_EN to make opcode 13 (ori) legal.
module ula_operand_stage #(
  parameter logic [31:0] RESET_PC_TAG = 32'd0
) (
  input  logic                clock,
  input  logic                resetN,
  ula_operand_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] FN_SLL    = 6'd0;
  localparam logic [5:0] FN_SRL    = 6'd2;
  localparam logic [5:0] FN_SRA    = 6'd3;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_AND   = 2'd1;
  localparam logic [1:0] ALU_RTYPE = 2'd2;
`ifdef ULA_STAGE_ORI_EN
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] FN_OR     = 6'd37;
`endif

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] rf_q [32];
  logic [31:0] input1_q, input2_q;
  logic [1:0]  alu_op_q;
  logic [5:0]  funct_q, opcode_q;
  logic [4:0]  dest_q;
  logic [31:0] result_q;
  logic [31:0] tag_q;

  logic accept, load_ops, capture, write_back, illegal;

  // Instruction fields of the latched word.
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;

  assign op     = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign fn     = instr_q[5:0];
  assign imm    = instr_q[15:0];
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  logic        dec_legal;
  logic [31:0] dec_in1, dec_in2;
  logic [1:0]  dec_alu_op;
  logic [5:0]  dec_funct;
  logic [4:0]  dec_dest;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    dec_legal  = 1'b1;
    dec_in1    = rs_val;
    dec_in2    = rt_val;
    dec_alu_op = ALU_RTYPE;
    dec_funct  = fn;
    dec_dest   = rd;
    case (op)
      OP_RTYPE: begin
        // Shifts take the amount from the instruction, not from rs.
        if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)
          dec_in1 = {27'd0, shamt};
      end
      OP_ADDI: begin
        dec_alu_op = ALU_ADD;
        dec_in2    = {{16{imm[15]}}, imm};
        dec_dest   = rt;
      end
      OP_ANDI: begin
        dec_alu_op = ALU_AND;
        dec_in2    = {16'd0, imm};
        dec_dest   = rt;
      end
`ifdef ULA_STAGE_ORI_EN
      OP_ORI: begin
        dec_funct = FN_OR;
        dec_in2   = {16'd0, imm};
        dec_dest  = rt;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_ops   = 1'b0;
    capture    = 1'b0;
    write_back = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instrValid) begin
          accept  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          load_ops = 1'b1;
          state_d  = EXECUTE;
        end else begin
          illegal = 1'b1;
          state_d = IDLE;
        end
      end
      EXECUTE: begin
        capture = 1'b1;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        write_back = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      instr_q  <= 32'd0;
      input1_q <= 32'd0;
      input2_q <= 32'd0;
      alu_op_q <= 2'd0;
      funct_q  <= 6'd0;
      opcode_q <= 6'd0;
      dest_q   <= 5'd0;
      result_q <= 32'd0;
      tag_q    <= RESET_PC_TAG;
    end else begin
      if (accept) instr_q <= bus.instrWord;
      if (load_ops) begin
        input1_q <= dec_in1;
        input2_q <= dec_in2;
        alu_op_q <= dec_alu_op;
        funct_q  <= dec_funct;
        opcode_q <= op;
        dest_q   <= dec_dest;
      end
      if (capture)    result_q <= bus.aluResult;
      if (write_back) tag_q    <= tag_q + 32'd1;
    end
  end

  // NOTE: the register file must clear on reset, so it is built from resettable flops, not an inferred RAM.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                             rf_q <= '{default: 32'd0};
    else if (write_back && dest_q != 5'd0)   rf_q[dest_q] <= result_q;
  end

  assign bus.instrReady   = (state_q == IDLE);
  assign bus.illegalInstr = illegal;
  assign bus.wbValid      = write_back;
  assign bus.wbAddr       = dest_q;
  assign bus.wbData       = result_q;
  assign bus.wbTag        = tag_q;
  assign bus.input1       = input1_q;
  assign bus.input2       = input2_q;
  assign bus.aluOp        = alu_op_q;
  assign bus.funct        = funct_q;
  assign bus.opCode       = opcode_q;
  assign bus.dbgData      = (bus.dbgAddr == 5'd0) ? 32'd0 : rf_q[bus.dbgAddr];

endmodule
